// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch handshake, decode, execute, memory
// wait and write-back, with datapath strobes held in registers alongside state.
module control_fsm #(
  parameter int INSTRUCTION_ADDR_SIZE = 5
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  instr_valid,
  input  logic [(2**INSTRUCTION_ADDR_SIZE)-1:0] instruction,
  input  logic                                  mem_ready,
  output logic                                  instr_ready,
  output logic [(2**INSTRUCTION_ADDR_SIZE)-1:0] ir_out,
  output logic [1:0]                            alu_op,
  output logic                                  alu_src,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic                                  reg_write,
  output logic                                  mem_to_reg,
  output logic                                  branch,
  output logic                                  pc_write,
  output logic                                  illegal,
  output logic [15:0]                           instr_count
);

  localparam int DATA_W = 2**INSTRUCTION_ADDR_SIZE;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef struct packed {
    logic       instr_ready;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       illegal;
  } strobe_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   ir_nxt;
  logic                retire;
  strobe_t             strb_q;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
  endfunction

  // Strobes are a pure function of (state, opcode); evaluating it on the
  // next-state values lets the registered copy line up with the state register.
  function automatic strobe_t decode_strobes(input state_t s, input logic [6:0] op);
    strobe_t o;
    o = '0;
    case (s)
      S_FETCH:  o.instr_ready = 1'b1;
      S_DECODE: o.illegal = !is_supported(op);
      S_EXEC: begin
        case (op)
          OP_R:         o.alu_op = 2'b10;
          OP_LD, OP_SD: o.alu_src = 1'b1;
          OP_BEQ: begin
            o.alu_op = 2'b01;
            o.branch = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        o.alu_src   = 1'b1;
        o.mem_read  = (op == OP_LD);
        o.mem_write = (op == OP_SD);
      end
      S_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = (op == OP_LD);
      end
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir_out;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (instr_valid) begin
          ir_nxt    = instruction;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = is_supported(ir_out[6:0]) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        case (ir_out[6:0])
          OP_R:         state_nxt = S_WB;
          OP_LD, OP_SD: state_nxt = S_MEM;
          OP_BEQ: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (ir_out[6:0] == OP_LD) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      ir_out      <= '0;
      instr_count <= '0;
      strb_q      <= decode_strobes(S_FETCH, 7'b0);
    end else begin
      state  <= state_nxt;
      ir_out <= ir_nxt;
      strb_q <= decode_strobes(state_nxt, ir_nxt[6:0]);
      if (retire) begin
        instr_count <= instr_count + 16'd1;
      end
    end
  end

  // The handshake strobe must fire in the accepting cycle, so it is the one
  // output taken combinationally; reset masks it so nothing is fetched.
  assign pc_write = (state == S_FETCH) && instr_valid && !reset;

  assign instr_ready = strb_q.instr_ready;
  assign alu_op      = strb_q.alu_op;
  assign alu_src     = strb_q.alu_src;
  assign mem_read    = strb_q.mem_read;
  assign mem_write   = strb_q.mem_write;
  assign reg_write   = strb_q.reg_write;
  assign mem_to_reg  = strb_q.mem_to_reg;
  assign branch      = strb_q.branch;
  assign illegal     = strb_q.illegal;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The module SHALL have parameter INSTRUCTION_ADDR_SIZE, default 5; instruction width is 2**INSTRUCTION_ADDR_SIZE (32 bits).
REQ-002 The module SHALL have port clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port instr_valid, input, 1 bit: the fetch source presents an instruction.
REQ-005 The module SHALL have port instruction, input, 32 bits: the instruction word, sampled only on fetch handshake.
REQ-006 The module SHALL have port mem_ready, input, 1 bit: data memory completes the current access.
REQ-007 The module SHALL have port instr_ready, output, 1 bit: the FSM accepts an instruction.
REQ-008 The module SHALL have port ir_out, output, 32 bits: the latched instruction register, which feeds the ALU instruction input.
REQ-009 The module SHALL have port alu_op, output, 2 bits: ALU operation class (00 add, 01 subtract, 10 funct-decoded).
REQ-010 The module SHALL have outputs alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch and pc_write, each 1 bit: datapath strobes.
REQ-011 The module SHALL have port illegal, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-012 The module SHALL have port instr_count, output, 16 bits: count of retired instructions.

Function
REQ-013 The FSM SHALL implement states FETCH, DECODE, EXEC, MEM and WB; all outputs are decoded from the current state and ir_out only (Moore).
REQ-014 In FETCH, instr_ready SHALL be 1; when instr_valid=1, ir_out loads instruction, pc_write=1 in that cycle, and the next state is DECODE; otherwise the FSM stays in FETCH.
REQ-015 In all states other than FETCH, instr_ready SHALL be 0 and ir_out SHALL hold its value.
REQ-016 In DECODE, supported opcodes (ir_out[6:0]) SHALL be R=0110011, LD=0000011, SD=0100011 and BEQ=1100011; a supported opcode goes to EXEC, any other opcode pulses illegal=1 and returns to FETCH.
REQ-017 In EXEC, alu_op SHALL be 10 for R, 00 for LD/SD and 01 for BEQ; alu_src=1 for LD/SD and 0 otherwise.
REQ-018 From EXEC, R SHALL go to WB, LD/SD SHALL go to MEM, and BEQ SHALL assert branch=1 for that cycle and go to FETCH.
REQ-019 In MEM, mem_read=1 (LD) or mem_write=1 (SD) SHALL be held every cycle until mem_ready=1; on mem_ready=1, LD goes to WB and SD goes to FETCH.
REQ-020 In MEM, alu_op SHALL remain 00 and alu_src SHALL remain 1 so the address is stable.
REQ-021 In WB, reg_write SHALL be 1, mem_to_reg SHALL be 1 for LD and 0 for R, and the next state SHALL be FETCH.
REQ-022 Outside the cases above, every strobe SHALL be 0 and alu_op SHALL be 00.
REQ-023 instr_count SHALL increment by 1 on each retirement: leaving WB, SD leaving MEM, or BEQ leaving EXEC; illegal instructions are not counted.
REQ-024 instr_count SHALL wrap from 0xFFFF to 0x0000.
REQ-025 Latency SHALL be: R=4 cycles, BEQ=3, SD=4+w, LD=5+w, where w = number of extra mem_ready=0 cycles; illegal = 2 cycles.
REQ-026 mem_ready SHALL be ignored outside MEM; instr_valid SHALL be ignored outside FETCH.

Reset
REQ-027 When reset=1 at a clock edge, the state SHALL go to FETCH, ir_out to 0 and instr_count to 0, regardless of state, including mid-MEM wait.
REQ-028 During and after reset, all strobes and illegal SHALL be 0 and alu_op SHALL be 00; instr_ready=1 in the first cycle after reset deasserts.
REQ-029 Reset SHALL take priority over the fetch handshake in the same cycle: the instruction is not latched and no pc_write is issued.

Verification
REQ-030 R-type add 0x002081B3, instr_valid=1 -> DECODE, then EXEC with alu_op=10 and alu_src=0, then WB with reg_write=1 and mem_to_reg=0; instr_count=1; back in FETCH 4 cycles after handshake.
REQ-031 LD 0x0000B183 with mem_ready low 2 cycles -> mem_read=1 for 3 cycles, then WB with mem_to_reg=1; total 7 cycles; instr_count increments once.
REQ-032 SD 0x0030B023 with mem_ready=1 immediately -> mem_write=1 for one cycle, no WB, return to FETCH; reg_write never 1.
REQ-033 BEQ 0x00208463 -> EXEC with alu_op=01 and branch=1, return to FETCH 3 cycles after handshake; opcode 0x7F -> illegal=1 pulse in DECODE, instr_count unchanged.
REQ-034 Preload instr_count=0xFFFF via 65535 BEQs, retire one more -> instr_count=0x0000; reset asserted during a MEM wait -> FETCH, mem_read=0 and instr_count=0 on the next cycle.
